// File: rtl/grid_mover.sv
// Player-movement engine: resolves button requests against wall bitmaps and steps the
// player one pixel per SPEED_FACTOR granted ticks. Optional turn buffer: TURN_BUFFER_EN.
module grid_mover #(
  parameter int unsigned GRID_W       = 10,
  parameter int unsigned GRID_H       = 15,
  parameter int unsigned CELL_BITS    = 5,
  parameter int unsigned SPEED_FACTOR = 8,
  localparam int unsigned MAX_DIM     = (GRID_W > GRID_H) ? GRID_W : GRID_H,
  localparam int unsigned POS_W       = $clog2(MAX_DIM) + CELL_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [(GRID_H+1)*GRID_W-1:0]   h_walls,
  input  logic [GRID_H*(GRID_W+1)-1:0]   v_walls,
  input  logic [3:0]                     btn,
  input  logic                           advance,
  output logic [POS_W-1:0]               pos_x,
  output logic [POS_W-1:0]               pos_y,
  output logic [1:0]                     direction,
  output logic                           blocked,
  output logic                           step,
  output logic [GRID_W*GRID_H-1:0]       visited,
  output logic                           all_visited
);

  localparam int unsigned CW    = POS_W - CELL_BITS;
  localparam int unsigned CntW  = (SPEED_FACTOR > 1) ? $clog2(SPEED_FACTOR) : 1;
  localparam int unsigned HIdxW = $clog2((GRID_H + 1) * GRID_W);
  localparam int unsigned VIdxW = $clog2(GRID_H * (GRID_W + 1));
  localparam int unsigned CIdxW = $clog2(GRID_W * GRID_H);
  localparam logic [CntW-1:0] CntReload = CntW'(SPEED_FACTOR - 1);

  typedef enum logic [0:0] {StAlign, StRun} state_e;

  state_e                      state_q;
  logic [3:0]                  btn_q;
  logic [CntW-1:0]             cnt_q;
  logic [POS_W-1:0]            pos_x_q, pos_y_q;
  logic [1:0]                  dir_q;
  logic                        blocked_q, step_q, all_q;
  logic [GRID_W*GRID_H-1:0]    visited_q;

  logic [CW-1:0]    cx, cy;
  logic [HIdxW-1:0] h_top, h_bot;
  logic [VIdxW-1:0] v_left, v_right;
  logic [CIdxW-1:0] cell_idx;
  logic [3:0]       open;
  logic [1:0]       pick_dir;
  logic [POS_W-1:0] pos_x_d, pos_y_d;
  logic             aligned_d;

`ifdef TURN_BUFFER_EN
  logic [3:0] btn_prev_q, pend_q, rise;
  assign rise = btn_q & ~btn_prev_q;
`endif

  assign cx = pos_x_q[POS_W-1:CELL_BITS];
  assign cy = pos_y_q[POS_W-1:CELL_BITS];

  always_comb begin
    cell_idx = CIdxW'(32'(cy) * GRID_W + 32'(cx));
    h_top    = HIdxW'(32'(cy) * GRID_W + 32'(cx));
    h_bot    = HIdxW'(32'(cy) * GRID_W + 32'(cx) + GRID_W);
    v_left   = VIdxW'(32'(cy) * (GRID_W + 1) + 32'(cx));
    v_right  = VIdxW'(32'(cy) * (GRID_W + 1) + 32'(cx) + 1);
    open[0]  = (32'(cx) != GRID_W - 1) && !v_walls[v_right];
    open[1]  = (32'(cy) != GRID_H - 1) && !h_walls[h_bot];
    open[2]  = (cx != '0) && !v_walls[v_left];
    open[3]  = (cy != '0) && !h_walls[h_top];
  end

  // Descending scan so the lowest open index wins; a buffered turn overrides held buttons.
  always_comb begin
    pick_dir = dir_q;
    for (int i = 3; i >= 0; i--) begin
      if (btn_q[i] && open[i]) pick_dir = 2'(i);
    end
`ifdef TURN_BUFFER_EN
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i] && open[i]) pick_dir = 2'(i);
    end
`endif
  end

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    case (dir_q)
      2'd0:    pos_x_d = pos_x_q + POS_W'(1);
      2'd1:    pos_y_d = pos_y_q + POS_W'(1);
      2'd2:    pos_x_d = pos_x_q - POS_W'(1);
      default: pos_y_d = pos_y_q - POS_W'(1);
    endcase
    aligned_d = (pos_x_d[CELL_BITS-1:0] == '0) && (pos_y_d[CELL_BITS-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StAlign;
      btn_q     <= '0;
      cnt_q     <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      dir_q     <= 2'd2;
      blocked_q <= 1'b0;
      step_q    <= 1'b0;
      visited_q <= '0;
      all_q     <= 1'b0;
`ifdef TURN_BUFFER_EN
      btn_prev_q <= '0;
      pend_q     <= '0;
`endif
    end else begin
      btn_q  <= btn;
      step_q <= 1'b0;
`ifdef TURN_BUFFER_EN
      btn_prev_q <= btn_q;
      if (state_q == StRun && rise != '0) begin
        pend_q <= rise;
      end else if (state_q == StAlign && advance) begin
        pend_q <= '0;
      end
`endif
      if (advance) begin
        all_q <= all_q | (&visited_q);
        case (state_q)
          StAlign: begin
            dir_q               <= pick_dir;
            blocked_q           <= !open[pick_dir];
            visited_q[cell_idx] <= 1'b1;
            cnt_q               <= CntReload;
            state_q             <= StRun;
          end
          default: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (!blocked_q) begin
              pos_x_q <= pos_x_d;
              pos_y_q <= pos_y_d;
              step_q  <= 1'b1;
              cnt_q   <= CntReload;
              if (aligned_d) state_q <= StAlign;
            end else begin
              state_q <= StAlign;
            end
          end
        endcase
      end
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign direction   = dir_q;
  assign blocked     = blocked_q;
  assign step        = step_q;
  assign visited     = visited_q;
  assign all_visited = all_q;

endmodule

// File: tb/tb_grid_mover.sv
// Directed bench for grid_mover: default 10x15 grid plus a 2x2 instance for all_visited.
module tb_grid_mover;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TURN_BUFFER_EN
  localparam logic [1:0] ExpTurn = 2'd1;
`else
  localparam logic [1:0] ExpTurn = 2'd0;
`endif

  logic         rst, advance;
  logic [159:0] h_walls;
  logic [149:0] v_walls;
  logic [3:0]   btn;
  logic [8:0]   pos_x, pos_y;
  logic [1:0]   direction;
  logic         blocked, step, all_visited;
  logic [149:0] visited;

  logic       rst2, adv2;
  logic [5:0] h2, v2;
  logic [3:0] btn2;
  logic [1:0] px2, py2, dir2;
  logic       blk2, step2, allv2;
  logic [3:0] vis2;

  grid_mover dut (
    .clk(clk), .rst(rst), .h_walls(h_walls), .v_walls(v_walls), .btn(btn),
    .advance(advance), .pos_x(pos_x), .pos_y(pos_y), .direction(direction),
    .blocked(blocked), .step(step), .visited(visited), .all_visited(all_visited)
  );

  grid_mover #(.GRID_W(2), .GRID_H(2), .CELL_BITS(1), .SPEED_FACTOR(1)) dut2 (
    .clk(clk), .rst(rst2), .h_walls(h2), .v_walls(v2), .btn(btn2),
    .advance(adv2), .pos_x(px2), .pos_y(py2), .direction(dir2),
    .blocked(blk2), .step(step2), .visited(vis2), .all_visited(allv2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_vis2(input int b, input string tag);
    int n = 0;
    while (!vis2[b] && n < 50) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(vis2[b]), 32'd1);
  endtask

  initial begin
    int steps, lat, gap;
    rst = 1'b0; advance = 1'b1; btn = '0; h_walls = '0; v_walls = '0;
    rst2 = 1'b0; adv2 = 1'b1; btn2 = '0; h2 = '0; v2 = '0;
    cyc(2);
    check("rst_pos_x", 32'(pos_x), 32'd0);
    check("rst_pos_y", 32'(pos_y), 32'd0);
    check("rst_dir", 32'(direction), 32'd2);
    check("rst_blocked", 32'(blocked), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_visited", 32'(visited != '0), 32'd0);
    check("rst_all", 32'(all_visited), 32'd0);

    // Idle at the origin facing left: blocked by the edge, never steps.
    rst = 1'b1;
    cyc(2);
    check("idle_dir", 32'(direction), 32'd2);
    check("idle_blocked", 32'(blocked), 32'd1);
    check("idle_vis0", 32'(visited[0]), 32'd1);
    steps = 0;
    repeat (40) begin
      cyc(1);
      if (step) steps++;
    end
    check("idle_steps", 32'(steps), 32'd0);

    // Open grid, hold right: press-to-step latency, spacing, cell crossing.
    rst = 1'b0; advance = 1'b0;
    cyc(1);
    rst = 1'b1; btn = 4'b0001;
    lat = 0;
    cyc(1); lat++;
    advance = 1'b1;
    while (!step && lat < 30) begin
      cyc(1); lat++;
    end
    check("latency", 32'(lat), 32'd10);
    check("right_dir", 32'(direction), 32'd0);
    check("right_pos1", 32'(pos_x), 32'd1);
    gap = 0;
    do begin
      cyc(1); gap++;
    end while (!step && gap < 30);
    check("step_gap", 32'(gap), 32'd8);
    btn = 4'b0011;
    cyc(1);
    btn = 4'b0001;
    steps = 2; gap = 0;
    while (pos_x != 9'd32 && gap < 3000) begin
      cyc(1); gap++;
      if (step) steps++;
    end
    check("cell_steps", 32'(steps), 32'd32);
    check("cell_pos_y", 32'(pos_y), 32'd0);
    check("vis1_before", 32'(visited[1]), 32'd0);
    cyc(1);
    check("vis1_after", 32'(visited[1]), 32'd1);
    check("turn_dir", 32'(direction), 32'(ExpTurn));
    check("turn_blocked", 32'(blocked), 32'd0);

    // Right wall of (0,0) closed: right+down held picks down.
    rst = 1'b0; advance = 1'b0; btn = '0; v_walls = '0; v_walls[1] = 1'b1;
    cyc(1);
    rst = 1'b1; btn = 4'b0011;
    cyc(1);
    advance = 1'b1;
    lat = 0;
    while (!step && lat < 30) begin
      cyc(1); lat++;
    end
    check("down_dir", 32'(direction), 32'd1);
    check("down_pos_y", 32'(pos_y), 32'd1);
    check("down_pos_x", 32'(pos_x), 32'd0);
    advance = 1'b0; steps = 0;
    repeat (20) begin
      cyc(1);
      if (step) steps++;
    end
    check("freeze_steps", 32'(steps), 32'd0);
    check("freeze_pos_y", 32'(pos_y), 32'd1);

    // Toggled grant halves the rate.
    gap = 0;
    do begin
      advance = ~advance; cyc(1); gap++;
    end while (!step && gap < 40);
    gap = 0;
    do begin
      advance = ~advance; cyc(1); gap++;
    end while (!step && gap < 40);
    check("toggle_gap", 32'(gap), 32'd16);
    check("toggle_pos_y", 32'(pos_y), 32'd3);
    advance = 1'b1; rst = 1'b0;
    cyc(1);
    check("midrst_pos_y", 32'(pos_y), 32'd0);
    check("midrst_dir", 32'(direction), 32'd2);
    check("midrst_visited", 32'(visited != '0), 32'd0);
    rst = 1'b1;

    // 2x2 tour: right, down, left.
    adv2 = 1'b0; rst2 = 1'b1; btn2 = 4'b0001;
    cyc(1);
    adv2 = 1'b1;
    wait_vis2(1, "tour_vis1");
    btn2 = 4'b0010;
    wait_vis2(3, "tour_vis3");
    btn2 = 4'b0100;
    wait_vis2(2, "tour_vis2");
    check("tour_all_vis", 32'(vis2), 32'd15);
    check("tour_allv_early", 32'(allv2), 32'd0);
    cyc(1);
    check("tour_allv_set", 32'(allv2), 32'd1);
    btn2 = '0;
    cyc(20);
    check("tour_allv_sticky", 32'(allv2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
